axi_read_master: RTL

- AXI4 read initiator. Accepts one command "read N 64-byte lines from address A" and issues the AR bursts on the _m channels.
- Streams R beats to a consumer over a valid/ready interface, then signals completion with an error status.
- Sits between accelerator datapath blocks (edge/vertex fetchers) and the AXI memory port. It pairs with the memory-side responder on the same 512-bit bus.

---
 rtl/axi_read_master_pkg.sv | 12 +
 rtl/axi_burst_calc.sv | 26 ++
 rtl/axi_read_master.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axi_read_master_pkg.sv
// Shared definitions for the AXI4 read initiator: AXI encodings, line/page
// geometry and the controller state type.
package axi_read_master_pkg;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [2:0]  SIZE_64B   = 3'd6;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned PAGE_LINES = 64;

  typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

endpackage

// File: rtl/axi_burst_calc.sv
// Burst length calculator.
//   rem      : lines still to request (32 bit)
//   line_idx : line index of the burst start within its 4 KB page (addr[11:6])
//   blen     : min(rem, MAX_BURST, lines left in the page); 0 only when rem is 0
module axi_burst_calc
  import axi_read_master_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [31:0] rem,
  input  logic [5:0]  line_idx,
  output logic [6:0]  blen
);

  localparam logic [6:0] MaxBurstW = 7'(MAX_BURST);

  logic [6:0] page_left;
  logic [6:0] cap;

  always_comb begin
    page_left = 7'(PAGE_LINES) - {1'b0, line_idx};
    cap       = (page_left < MaxBurstW) ? page_left : MaxBurstW;
    blen      = (rem < {25'b0, cap}) ? rem[6:0] : cap;
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read initiator: accepts "read N 64-byte lines from address A", issues
// page-safe AR bursts one at a time and streams R beats to a consumer.
//   req_*       : command handshake (addr, line count)
//   out_*       : line stream to consumer; out_last marks final line of command
//   done / err  : one-cycle completion pulse and its error status
//   ar*_m / r*_m: AXI4 AR and R channels (512-bit data)
module axi_read_master
  import axi_read_master_pkg::*;
#(
  parameter logic [15:0] ID        = 16'h0,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  req_addr,
  input  logic [31:0]  req_lines,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [511:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         done,
  output logic         err,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m
);

  localparam logic [63:0] LineMask = 64'(LINE_BYTES - 1);

  state_e      state_q;
  logic [63:0] addr_q;
  logic [31:0] rem_q;
  logic [6:0]  blen_q;
  logic [6:0]  beat_q;
  logic        err_q;

  logic [31:0] calc_rem;
  logic [5:0]  calc_idx;
  logic [6:0]  calc_blen;
  logic [63:0] req_addr_al;

  assign req_addr_al = req_addr & ~LineMask;

  // In IDLE the next burst is sized from the incoming command, otherwise from
  // the already-advanced rem/addr registers.
  always_comb begin
    if (state_q == StIdle) begin
      calc_rem = req_lines;
      calc_idx = req_addr_al[11:6];
    end else begin
      calc_rem = rem_q;
      calc_idx = addr_q[11:6];
    end
  end

  axi_burst_calc #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .rem      (calc_rem),
    .line_idx (calc_idx),
    .blen     (calc_blen)
  );

  // Outputs decoded from registered state only.
  assign req_ready = (state_q == StIdle);
  assign arvalid_m = (state_q == StAr);
  assign araddr_m  = addr_q;
  assign arlen_m   = {1'b0, blen_q - 7'd1};
  assign arsize_m  = SIZE_64B;
  assign arid_m    = ID;
  assign done      = (state_q == StDone);
  assign err       = err_q;

  // R channel passes straight through to the consumer.
  assign out_data  = rdata_m;
  assign out_valid = (state_q == StR) && rvalid_m;
  assign rready_m  = (state_q == StR) && out_ready;
  assign out_last  = (state_q == StR) && rlast_m && (rem_q == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= req_addr_al;
            rem_q   <= req_lines;
            err_q   <= 1'b0;
            blen_q  <= calc_blen;
            state_q <= (req_lines != 32'd0) ? StAr : StDone;
          end
        end
        StAr: begin
          if (arready_m) begin
            beat_q  <= blen_q;
            rem_q   <= rem_q - {25'b0, blen_q};
            addr_q  <= addr_q + 64'(blen_q) * 64'(LINE_BYTES);
            state_q <= StR;
          end
        end
        StR: begin
          if (rvalid_m && rready_m) begin
            beat_q <= beat_q - 7'd1;
            // Early/missing rlast is flagged, but beat_q alone ends the burst.
            if (rresp_m != RESP_OKAY || rid_m != ID || rlast_m != (beat_q == 7'd1)) begin
              err_q <= 1'b1;
            end
            if (beat_q == 7'd1) begin
              if (rem_q != 32'd0) begin
                blen_q  <= calc_blen;
                state_q <= StAr;
              end else begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
